// File: rtl/flofifo_mc_pkg.sv
// flofifo_mc shared types, defaults and the
// sticky-flag update rule.
package flofifo_mc_pkg;

    localparam int DEF_NCHAN    = 4;
    localparam int DEF_WIDTH    = 24;
    localparam int DEF_LENGTH   = 32;
    localparam int DEF_AF_LEVEL = 28;

    typedef struct packed {
        logic ovf;
        logic udf;
    } flags_t;

    // set wins over clear on the same edge
    function automatic flags_t upd_flags(
        input flags_t f,
        input logic   clr,
        input logic   ovf_ev,
        input logic   udf_ev
    );
        flags_t n;
        n.ovf = (f.ovf & ~clr) | ovf_ev;
        n.udf = (f.udf & ~clr) | udf_ev;
        return n;
    endfunction

endpackage

// File: rtl/flofifo_chan.sv
// Single-channel synchronous FIFO with registered
// read data, occupancy, flush and sticky flags.
`include "flofifo_defs.vh"

module flofifo_chan
    import flofifo_mc_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LENGTH   = DEF_LENGTH,
    parameter int AF_LEVEL = DEF_AF_LEVEL
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         valid_i,
    input  logic                         read_i,
    input  logic                         flush_i,
    input  logic                         clear_flags_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         valid_o,
    output logic [`FLOFIFO_LW(LENGTH)-1:0] locs_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         almost_full_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int LW = `FLOFIFO_LW(LENGTH);
    localparam int AW = LW - 1;

    logic [WIDTH-1:0] mem [LENGTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LW-1:0]    occ;
    flags_t           flg;

    logic empty;
    logic full;
    logic rd_ok;
    logic wr_ok;
    logic ovf_ev;
    logic udf_ev;

    assign empty  = (occ == '0);
    assign full   = (occ == LW'(LENGTH));
    assign rd_ok  = read_i && !empty;
    // at full a same-edge read frees the slot
    assign wr_ok  = valid_i && (!full || rd_ok);
    assign ovf_ev = !flush_i && valid_i && !wr_ok;
    assign udf_ev = !flush_i && read_i && empty;

    always_ff @(posedge clk) begin
        if (!rst && !flush_i && wr_ok) begin
            mem[wptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            occ     <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            flg     <= '0;
        end else begin
            flg <= upd_flags(flg, clear_flags_i,
                             ovf_ev, udf_ev);
            if (flush_i) begin
                wptr    <= '0;
                rptr    <= '0;
                occ     <= '0;
                valid_o <= 1'b0;
            end else begin
                valid_o <= rd_ok;
                if (rd_ok) begin
                    data_o <= mem[rptr];
                    rptr   <= rptr + AW'(1);
                end
                if (wr_ok) begin
                    wptr <= wptr + AW'(1);
                end
                occ <= occ + LW'(wr_ok) - LW'(rd_ok);
            end
        end
    end

    assign locs_o        = occ;
    assign empty_o       = empty;
    assign full_o        = full;
    assign almost_full_o = (occ >= LW'(AF_LEVEL));
    assign overflow_o    = flg.ovf;
    assign underflow_o   = flg.udf;

endmodule

// File: rtl/flofifo_defs.vh
// flofifo shared macros: occupancy width and
// elaboration-time parameter check.
`ifndef FLOFIFO_DEFS_VH
`define FLOFIFO_DEFS_VH

`define FLOFIFO_LW(L) ($clog2(L) + 1)

`define FLOFIFO_CHECK(L, AF) \
    if ((L) < 2 || ((L) & ((L) - 1)) != 0 || \
        (AF) < 1 || (AF) > (L)) begin : g_param_err \
        $error("flofifo: illegal LENGTH or AF_LEVEL"); \
    end

`endif

// File: rtl/flofifo_mc.sv
// NCHAN independent FIFOs; slices the packed buses
// and instantiates one flofifo_chan per channel.
`include "flofifo_defs.vh"

module flofifo_mc
    import flofifo_mc_pkg::*;
#(
    parameter int NCHAN    = DEF_NCHAN,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LENGTH   = DEF_LENGTH,
    parameter int AF_LEVEL = DEF_AF_LEVEL
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCHAN*WIDTH-1:0] data_i,
    input  logic [NCHAN-1:0]       valid_i,
    input  logic [NCHAN-1:0]       read_i,
    input  logic [NCHAN-1:0]       flush_i,
    input  logic                   clear_flags_i,
    output logic [NCHAN*WIDTH-1:0] data_o,
    output logic [NCHAN-1:0]       valid_o,
    output logic [NCHAN*`FLOFIFO_LW(LENGTH)-1:0] locs_o,
    output logic [NCHAN-1:0]       empty_o,
    output logic [NCHAN-1:0]       full_o,
    output logic [NCHAN-1:0]       almost_full_o,
    output logic [NCHAN-1:0]       overflow_o,
    output logic [NCHAN-1:0]       underflow_o
);

    localparam int LW = `FLOFIFO_LW(LENGTH);

    `FLOFIFO_CHECK(LENGTH, AF_LEVEL)

    for (genvar c = 0; c < NCHAN; c++) begin : g_ch
        flofifo_chan #(
            .WIDTH    (WIDTH),
            .LENGTH   (LENGTH),
            .AF_LEVEL (AF_LEVEL)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .data_i        (data_i[c*WIDTH +: WIDTH]),
            .valid_i       (valid_i[c]),
            .read_i        (read_i[c]),
            .flush_i       (flush_i[c]),
            .clear_flags_i (clear_flags_i),
            .data_o        (data_o[c*WIDTH +: WIDTH]),
            .valid_o       (valid_o[c]),
            .locs_o        (locs_o[c*LW +: LW]),
            .empty_o       (empty_o[c]),
            .full_o        (full_o[c]),
            .almost_full_o (almost_full_o[c]),
            .overflow_o    (overflow_o[c]),
            .underflow_o   (underflow_o[c])
        );
    end

endmodule
